// File: rtl/ssd_scan_n_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table, segment bit
// positions and the one-hot COM drive helper.
package ssd_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs in {g,f,e,d,c,b,a} order, active-high, indexed by nibble value.
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam int MAX_DIGITS = 8;

  // One-hot enable for digit idx; inverted when the COM lines are active-low.
  function automatic logic [MAX_DIGITS-1:0] com_drive(input logic [2:0] idx,
                                                      input logic active_low);
    logic [MAX_DIGITS-1:0] onehot;
    onehot = MAX_DIGITS'(1) << idx;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/ssd_scan_n_if.sv
// Bus between the datapath and the display scanner. Bright exists only when
// SSD_BRIGHT_EN is defined.
interface ssd_scan_n_if #(
  parameter int DIGITS = 4
);
  // Load is a one-cycle strobe that is always accepted (no back-pressure).
  // Pend is high while captured data waits for the next frame wrap; a Load
  // while Pend is high replaces the waiting data.
  logic [4*DIGITS-1:0] Data;
  logic [DIGITS-1:0]   Dp;
  logic                Load;
  logic                Blank_lz;
  logic                Pend;
  logic                Frame;
  logic [DIGITS-1:0]   COM;
  logic [6:0]          Seg;
  logic                Dp_out;
`ifdef SSD_BRIGHT_EN
  logic [3:0]          Bright;

  modport master (output Data, Dp, Load, Blank_lz, Bright,
                  input  Pend, Frame, COM, Seg, Dp_out);
  modport slave  (input  Data, Dp, Load, Blank_lz, Bright,
                  output Pend, Frame, COM, Seg, Dp_out);
`else
  modport master (output Data, Dp, Load, Blank_lz,
                  input  Pend, Frame, COM, Seg, Dp_out);
  modport slave  (input  Data, Dp, Load, Blank_lz,
                  output Pend, Frame, COM, Seg, Dp_out);
`endif
endinterface

// File: rtl/ssd_scan_n_hex7.sv
// Combinational nibble-to-glyph decoder for the currently scanned digit.
module ssd_hex7
  import ssd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg[SEG_G:SEG_A] = HEX7[digit];
endmodule

// File: rtl/ssd_scan_n.sv
// Multiplexed N-digit seven-segment scanner with tear-free frame commit and
// leading-zero blanking. Define SSD_BRIGHT_EN to add the 16-step Bright input.
module ssd_scan_n
  import ssd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int DIV_W          = 16,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input logic         Clk,
  input logic         Aclr,
  ssd_scan_n_if.slave bus
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] COM_IDLE = {DIGITS{COM_ACTIVE_LOW}};

  logic [DIV_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic                wrap;
  logic [4*DIGITS-1:0] disp;
  logic [DIGITS-1:0]   disp_dp;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend;
  logic                frame;
  logic [DIGITS-1:0]   com;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   lz;
  logic                blank;
  logic                gate;
  logic                show;
  logic [3:0]          cur_digit;
  logic [6:0]          cur_seg;
  logic [DIGITS-1:0]   com_sel;

  assign tick = (presc == DIV_W'(DIV - 1));
  assign wrap = tick && (idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge Clk) begin
    if (Aclr) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Display buffer only changes on the wrap so a frame never mixes old and new
  // digits; a Load on that same edge lands in pending for the following frame.
  always_ff @(posedge Clk) begin
    if (Aclr) begin
      disp      <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend      <= 1'b0;
    end else begin
      if (wrap && pend) begin
        disp    <= pend_data;
        disp_dp <= pend_dp;
      end
      if (bus.Load) begin
        pend_data <= bus.Data;
        pend_dp   <= bus.Dp;
      end
      pend <= bus.Load | (pend & ~wrap);
    end
  end

  // lz[i] is set when digit i and every digit to its left are zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'd0);
    end
  end

  assign blank     = bus.Blank_lz && (idx != '0) && lz[idx];
  assign cur_digit = disp[4*idx +: 4];
  assign com_sel   = DIGITS'(com_drive(3'(idx), COM_ACTIVE_LOW));

  ssd_hex7 u_hex7 (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

`ifdef SSD_BRIGHT_EN
  localparam int PH_LEN = DIV / 16;

  logic [DIV_W-1:0] ph_cnt;
  logic [3:0]       phase;
  logic [3:0]       bright_q;
  logic [3:0]       bright_now;

  // Bright is taken live on the first cycle of a slot and held for the rest.
  assign bright_now = (presc == '0) ? bus.Bright : bright_q;

  always_ff @(posedge Clk) begin
    if (Aclr) begin
      ph_cnt   <= '0;
      phase    <= '0;
      bright_q <= '0;
    end else begin
      if (presc == '0) bright_q <= bus.Bright;
      if (tick) begin
        ph_cnt <= '0;
        phase  <= '0;
      end else if (ph_cnt == DIV_W'(PH_LEN - 1)) begin
        ph_cnt <= '0;
        phase  <= phase + 1'b1;
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  assign gate = (phase <= bright_now);
`else
  assign gate = 1'b1;
`endif

  // Last cycle of every slot is dead time so the old glyph never ghosts.
  assign show = !tick && gate;

  always_ff @(posedge Clk) begin
    if (Aclr) begin
      com    <= COM_IDLE;
      seg    <= '0;
      dp_out <= 1'b0;
      frame  <= 1'b0;
    end else begin
      frame <= wrap;
      if (show) begin
        com    <= com_sel;
        seg    <= blank ? 7'h00 : cur_seg;
        dp_out <= disp_dp[idx];
      end else begin
        com    <= COM_IDLE;
        seg    <= '0;
        dp_out <= 1'b0;
      end
    end
  end

  assign bus.Pend   = pend;
  assign bus.Frame  = frame;
  assign bus.COM    = com;
  assign bus.Seg    = seg;
  assign bus.Dp_out = dp_out;

endmodule

// File: doc/ssd_scan_n.md
Name: ssd_scan_n

Overview:
- Parametrised multiplexed seven-segment display scanner for an N-digit common-electrode module.
- Cycles one-hot digit-enable (COM) lines at a programmable rate.
- Hex-decodes each digit's 4-bit value onto the segment bus, with per-digit decimal point, leading-zero blanking and frame-synchronous, tear-free data update.
- Sits between the datapath (counters, registers) and the board display pins; replaces fixed-pattern 4-digit scanning.

Parameters:
- DIGITS, 4: number of digits/COM lines (2..8).
- DIV, 50000: Clk cycles per digit slot (>=4).
- DIV_W, 16: prescaler width; 2**DIV_W >= DIV.
- COM_ACTIVE_LOW, 1: 1 = selected COM driven 0, idle COM 1; 0 = inverted.

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Aclr  in  1  synchronous, active-high reset.
- Data  in  4*DIGITS  digit values; Data[4i+3:4i] is digit i; digit 0 is rightmost.
- Dp  in  DIGITS  decimal point per digit, 1 = lit.
- Load  in  1  one-cycle strobe; captures Data/Dp into the pending buffer.
- Blank_lz  in  1  1 = suppress leading zeros.
- Pend  out  1  1 while captured data awaits commit.
- Frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.
- COM  out  DIGITS  digit enables, polarity per COM_ACTIVE_LOW.
- Seg  out  7  {g,f,e,d,c,b,a}, active-high.
- Dp_out  out  1  decimal point segment, active-high.

Behaviour:
- Reset (Aclr=1 at an edge):
  - prescaler=0, idx=0, display and pending buffers=0, Pend=0, Frame=0.
  - COM all inactive, Seg=0, Dp_out=0.
  - Reset asserted mid-frame or mid-pending gives the same state at the next edge; pending data is discarded.
- Prescaler: counts 0..DIV-1, then wraps to 0. A tick occurs when prescaler==DIV-1.
- Digit index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1. Frame=1 in the cycle after a tick that wraps idx to 0.
- Outputs: registered, 1-cycle latency from the idx/prescaler state.
  - While prescaler==DIV-1 (last slot cycle), all COM are inactive and Seg=0. This is dead time for ghost suppression.
  - Otherwise, COM[idx] is active, Seg=hex7(disp[idx]) and Dp_out=disp_dp[idx].
- hex7 encoding, bits gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking (Blank_lz=1):
  - Digit i is blanked (Seg=0) if disp[j]==0 for all j>=i, and i!=0.
  - Digit 0 is never blanked.
  - Dp of a blanked digit still shows.
  - Blank_lz is sampled live each slot.
- Load/commit handshake:
  - Load=1 copies Data/Dp into the pending buffer and sets Pend=1 next cycle.
  - Commit happens on a wrapping tick with Pend=1: display buffer <= pending, Pend <= 0.
  - Load with Pend=1: overwrites the pending data (last write wins); Pend stays 1.
  - Load in the same cycle as a committing wrap tick: the old pending data commits, the new data is captured, and Pend stays 1 (commits next frame).
  - Data changes without Load never affect the display.

Optional Feature:
- Macro SSD_BRIGHT_EN.
- Defined:
  - Adds port Bright in 4. DIV must be a multiple of 16.
  - Each slot is split into 16 equal phases; phase = prescaler/(DIV/16), tracked by a secondary counter, not a divider.
  - COM[idx] is active only while phase <= Bright. Bright=15 gives full slot less the dead cycle; Bright=0 gives 1/16.
  - Seg and Dp_out follow COM gating.
  - Bright is sampled at slot start.
- Undefined: no Bright port; always full duty.

Decomposition:
- Package ssd_pkg holds:
  - HEX7 16-entry localparam table.
  - Segment bit-index localparams.
  - Function com_drive(idx, active_low).
- One sub-module ssd_hex7 (4-bit in, 7-bit out, combinational), instantiated once on the muxed digit.

Test Plan (DIGITS=4, DIV=4, COM_ACTIVE_LOW=1):
- Reset, hold Aclr 3 cycles, release → COM=4'b1111, Seg=0, Pend=0.
- Then idx visits 0,1,2,3,0 every 4 cycles, and Frame pulses every 16 cycles.
- Load Data=16'h12AF, Dp=4'b0100 mid-frame → Pend=1 until the next wrap, then the slot for digit 0 shows Seg=7'h71 and COM=4'b1110.
- Digit 2 shows Seg=7'h5B with Dp_out=1; dead cycle COM=4'b1111.
- Load 16'h0007, then Blank_lz=1 → digits 3..1 show Seg=0 and digit 0 shows 7'h07.
- Load 16'h0000 → only digit 0 shows 7'h3F.
- Two Loads in one frame (16'h1111, then 16'h2222) → after the wrap only 2222 is displayed.
- Load coincident with a committing tick → old pending shown this frame, new data next frame, Pend high across the wrap.
- Aclr mid-pending → Pend=0, display stays 0000 and never shows the discarded data.
- With SSD_BRIGHT_EN, DIV=16, Bright=3 → COM[idx] is active 4 of 16 cycles per slot.
